// File: rtl/hazard_unit_mc_if.sv
// rtl/hazard_unit_mc_if.sv - pipeline hazard bus between the F/D/E/M/W datapath and the hazard unit
//
// Purpose : groups the decode/execute/memory/writeback hazard inputs and the
//           stall/flush/forward controls into one bundle.
// Modports: master - pipeline side (drives hazard inputs, receives controls)
//           slave  - hazard unit side (receives inputs, drives controls)
interface hazard_unit_mc_if #(
  parameter int AW   = 4,
  parameter int NSRC = 3
);
  logic [NSRC*AW-1:0] ra_d;
  logic [NSRC-1:0]    use_d;
  logic [NSRC*AW-1:0] ra_e;
  logic [NSRC-1:0]    use_e;
  logic [AW-1:0]      wa_e;
  logic [AW-1:0]      wa_m;
  logic [AW-1:0]      wa_w;
  logic               regwrite_e;
  logic               regwrite_m;
  logic               regwrite_w;
  logic               memtoreg_e;
  logic               long_e;
  logic               branch_taken_e;
  logic [2*NSRC-1:0]  forward_e;
  logic               stall_f;
  logic               stall_d;
  logic               stall_e;
  logic               flush_d;
  logic               flush_e;
  logic               busy;

  modport master (
    output ra_d, use_d, ra_e, use_e, wa_e, wa_m, wa_w,
    output regwrite_e, regwrite_m, regwrite_w, memtoreg_e, long_e, branch_taken_e,
    input  forward_e, stall_f, stall_d, stall_e, flush_d, flush_e, busy
  );

  modport slave (
    input  ra_d, use_d, ra_e, use_e, wa_e, wa_m, wa_w,
    input  regwrite_e, regwrite_m, regwrite_w, memtoreg_e, long_e, branch_taken_e,
    output forward_e, stall_f, stall_d, stall_e, flush_d, flush_e, busy
  );
endinterface

// File: rtl/hazard_unit_mc.sv
// rtl/hazard_unit_mc.sv - multi-source hazard unit with multicycle Execute hold controller
//
// Purpose : operand forwarding for NSRC sources, load-use stall, branch flush
//           and a small FSM that holds Execute for LONG_LAT cycles on long ops.
// Ports   : clk   - clock, all state on rising edge
//           rst   - asynchronous active-high reset
//           hz_bus - hazard_unit_mc_if.slave, hazard inputs and stall/flush/forward outputs
module hazard_unit_mc #(
  parameter int AW       = 4,
  parameter int NSRC     = 3,
  parameter int LONG_LAT = 4
) (
  input  logic                clk,
  input  logic                rst,
  hazard_unit_mc_if.slave     hz_bus
);

  localparam int          CW       = $clog2(LONG_LAT);
  localparam int          CNT_INIT = (LONG_LAT > 2) ? LONG_LAT - 3 : 0;
  localparam logic [AW-1:0] PC_ADDR = '1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          lstall;
  logic          busy_c;
  logic          ld_hit;
  logic          ldstall;
  logic          long_eff;
  logic [2*NSRC-1:0] fwd;

  // Forwarding: M result is newer than W, so it wins. The PC alias is never
  // forwarded because it is not produced by the ALU path.
  always_comb begin
    fwd = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz_bus.use_e[i] && hz_bus.regwrite_m &&
          hz_bus.wa_m == hz_bus.ra_e[i*AW +: AW] &&
          hz_bus.ra_e[i*AW +: AW] != PC_ADDR) begin
        fwd[2*i +: 2] = 2'b10;
      end else if (hz_bus.use_e[i] && hz_bus.regwrite_w &&
                   hz_bus.wa_w == hz_bus.ra_e[i*AW +: AW] &&
                   hz_bus.ra_e[i*AW +: AW] != PC_ADDR) begin
        fwd[2*i +: 2] = 2'b01;
      end
    end
  end

  always_comb begin
    ld_hit = 1'b0;
    for (int i = 0; i < NSRC; i++) begin
      if (hz_bus.use_d[i] && hz_bus.ra_d[i*AW +: AW] == hz_bus.wa_e) begin
        ld_hit = 1'b1;
      end
    end
  end

  assign ldstall  = hz_bus.memtoreg_e && hz_bus.regwrite_e && ld_hit;
  // A load in Execute is never a long op; the load-use path takes precedence.
  assign long_eff = hz_bus.long_e && !hz_bus.memtoreg_e;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The first stall cycle is raised combinationally in IDLE so the op is held
  // on its very first Execute cycle; BUSY covers the rest, RELEASE lets it go.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lstall  = 1'b0;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (long_eff) begin
          lstall = 1'b1;
          busy_c = 1'b1;
          if (LONG_LAT == 2) begin
            state_d = RELEASE;
          end else begin
            state_d = BUSY;
            cnt_d   = CW'(CNT_INIT);
          end
        end
      end
      BUSY: begin
        lstall = 1'b1;
        busy_c = 1'b1;
        if (cnt_q == '0) begin
          state_d = RELEASE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RELEASE: begin
        busy_c  = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign hz_bus.forward_e = fwd;
  assign hz_bus.stall_f   = ldstall | lstall;
  assign hz_bus.stall_d   = ldstall | lstall;
  assign hz_bus.stall_e   = lstall;
  // Execute holds during a long op; bubbling it would lose the op in flight.
  assign hz_bus.flush_e   = (ldstall | hz_bus.branch_taken_e) && !lstall;
  assign hz_bus.flush_d   = hz_bus.branch_taken_e && !lstall;
  assign hz_bus.busy      = busy_c;

endmodule

// File: tb/tb_hazard_unit_mc.sv
// tb/tb_hazard_unit_mc.sv - self-checking bench for hazard_unit_mc (LONG_LAT 4 and 2)
module tb_hazard_unit_mc;

  localparam int AW   = 4;
  localparam int NSRC = 3;

  // {forward_e[5:0], stall_f, stall_d, stall_e, flush_d, flush_e, busy}
  localparam logic [11:0] Z      = 12'b000000_000000;
  localparam logic [11:0] LST    = 12'b000000_111001;
  localparam logic [11:0] REL    = 12'b000000_000001;
  localparam logic [11:0] LDST   = 12'b000000_110010;
  localparam logic [11:0] BR     = 12'b000000_000110;
  localparam logic [11:0] BR_REL = 12'b000000_000111;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  hazard_unit_mc_if #(.AW(AW), .NSRC(NSRC)) hif4 ();
  hazard_unit_mc_if #(.AW(AW), .NSRC(NSRC)) hif2 ();

  assign hif2.ra_d           = hif4.ra_d;
  assign hif2.use_d          = hif4.use_d;
  assign hif2.ra_e           = hif4.ra_e;
  assign hif2.use_e          = hif4.use_e;
  assign hif2.wa_e           = hif4.wa_e;
  assign hif2.wa_m           = hif4.wa_m;
  assign hif2.wa_w           = hif4.wa_w;
  assign hif2.regwrite_e     = hif4.regwrite_e;
  assign hif2.regwrite_m     = hif4.regwrite_m;
  assign hif2.regwrite_w     = hif4.regwrite_w;
  assign hif2.memtoreg_e     = hif4.memtoreg_e;
  assign hif2.long_e         = hif4.long_e;
  assign hif2.branch_taken_e = hif4.branch_taken_e;

  hazard_unit_mc #(.AW(AW), .NSRC(NSRC), .LONG_LAT(4)) u_dut4 (
    .clk    (clk),
    .rst    (rst),
    .hz_bus (hif4)
  );

  hazard_unit_mc #(.AW(AW), .NSRC(NSRC), .LONG_LAT(2)) u_dut2 (
    .clk    (clk),
    .rst    (rst),
    .hz_bus (hif2)
  );

  typedef struct {
    string       tag;
    bit          sel2;
    logic [11:0] exp;
  } sb_entry_t;

  sb_entry_t sb[$];
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b", tag, got, exp);
    end
  endtask

  function automatic logic [11:0] obs4();
    return {hif4.forward_e, hif4.stall_f, hif4.stall_d, hif4.stall_e,
            hif4.flush_d, hif4.flush_e, hif4.busy};
  endfunction

  function automatic logic [11:0] obs2();
    return {hif2.forward_e, hif2.stall_f, hif2.stall_d, hif2.stall_e,
            hif2.flush_d, hif2.flush_e, hif2.busy};
  endfunction

  task automatic push(input string tag, input logic [11:0] e4, input logic [11:0] e2);
    sb_entry_t a;
    sb_entry_t b;
    a.tag = {tag, "/ll4"}; a.sel2 = 1'b0; a.exp = e4;
    b.tag = {tag, "/ll2"}; b.sel2 = 1'b1; b.exp = e2;
    sb.push_back(a);
    sb.push_back(b);
  endtask

  // Outputs are combinational, so they are valid shortly after the inputs move.
  task automatic drain();
    sb_entry_t e;
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      check(e.tag, e.sel2 ? obs2() : obs4(), e.exp);
    end
  endtask

  task automatic clear_inputs();
    hif4.ra_d = '0; hif4.use_d = '0; hif4.ra_e = '0; hif4.use_e = '0;
    hif4.wa_e = '0; hif4.wa_m = '0; hif4.wa_w = '0;
    hif4.regwrite_e = 1'b0; hif4.regwrite_m = 1'b0; hif4.regwrite_w = 1'b0;
    hif4.memtoreg_e = 1'b0; hif4.long_e = 1'b0; hif4.branch_taken_e = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    clear_inputs();
    push("reset_now", Z, Z);
    drain();
    @(negedge clk);
    push("reset_hold", Z, Z);
    drain();

    @(negedge clk);
    rst = 1'b0;
    push("idle_zero", Z, Z);
    drain();

    // Forwarding
    @(negedge clk);
    hif4.ra_e = {4'd2, 4'd1, 4'd1}; hif4.use_e = 3'b111;
    hif4.wa_m = 4'd1; hif4.regwrite_m = 1'b1;
    hif4.wa_w = 4'd2; hif4.regwrite_w = 1'b1;
    push("fwd_basic", 12'b011010_000000, 12'b011010_000000);
    drain();
    hif4.ra_e = {4'd2, 4'd1, 4'hF};
    push("fwd_pc_src0", 12'b011000_000000, 12'b011000_000000);
    drain();
    hif4.ra_e = {4'hF, 4'hF, 4'hF}; hif4.wa_m = 4'hF; hif4.wa_w = 4'hF;
    push("fwd_pc_all", Z, Z);
    drain();
    hif4.ra_e = {4'd1, 4'd1, 4'd1}; hif4.wa_m = 4'd1; hif4.wa_w = 4'd1;
    push("fwd_m_prio", 12'b101010_000000, 12'b101010_000000);
    drain();
    hif4.regwrite_m = 1'b0; hif4.use_e = 3'b101;
    push("fwd_w_only", 12'b010001_000000, 12'b010001_000000);
    drain();
    clear_inputs();

    // Load-use
    @(negedge clk);
    hif4.memtoreg_e = 1'b1; hif4.regwrite_e = 1'b1; hif4.wa_e = 4'd3;
    hif4.ra_d = {4'd0, 4'd3, 4'd0}; hif4.use_d = 3'b010;
    push("ldstall_hit", LDST, LDST);
    drain();
    hif4.use_d = 3'b000;
    push("ldstall_unused", Z, Z);
    drain();
    hif4.use_d = 3'b010; hif4.regwrite_e = 1'b0;
    push("ldstall_nowrite", Z, Z);
    drain();
    hif4.regwrite_e = 1'b1; hif4.long_e = 1'b1;
    push("load_over_long", LDST, LDST);
    drain();
    @(negedge clk);
    clear_inputs();
    push("load_no_fsm", Z, Z);
    drain();

    // Branch in IDLE
    hif4.branch_taken_e = 1'b1;
    push("branch_idle", BR, BR);
    drain();
    clear_inputs();

    // Long op held; LL2 instance restarts back-to-back
    @(negedge clk);
    hif4.long_e = 1'b1;
    push("long_t0", LST, LST);
    drain();
    @(negedge clk);
    push("long_t1", LST, REL);
    drain();
    @(negedge clk);
    hif4.branch_taken_e = 1'b1;
    push("long_t2_branch", LST, LST);
    drain();
    @(negedge clk);
    push("long_t3_release_branch", BR_REL, BR_REL);
    drain();
    @(negedge clk);
    hif4.branch_taken_e = 1'b0;
    push("long_b2b_t0", LST, LST);
    drain();
    @(negedge clk);
    hif4.long_e = 1'b0;
    push("long_b2b_t1", LST, REL);
    drain();
    @(negedge clk);
    push("long_b2b_t2", LST, Z);
    drain();

    // Asynchronous reset mid-op
    rst = 1'b1;
    push("async_rst", Z, Z);
    drain();

    @(negedge clk);
    rst = 1'b0;
    hif4.long_e = 1'b1;
    push("restart_t0", LST, LST);
    drain();
    @(negedge clk);
    hif4.long_e = 1'b0;
    push("restart_t1", LST, REL);
    drain();
    @(negedge clk);
    push("restart_t2", LST, Z);
    drain();
    @(negedge clk);
    push("restart_t3", REL, Z);
    drain();
    @(negedge clk);
    push("restart_t4", Z, Z);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_unit_mc.md
Name: hazard_unit_mc

Overview:
- Parametrised successor to the single-issue hazard unit of the Filter-GPU pipeline (F/D/E/M/W).
- Generalises operand forwarding and load-use detection to NSRC source operands.
- Adds a sequential multicycle-op controller: it holds the Execute stage while long-latency filter ops (MAC/divide) complete.
- Also generates branch flushes.

Parameters:
- AW, 4: register address width; address all-ones (PC) is never forwarded.
- NSRC, 3: source operands per instruction.
- LONG_LAT, 4: cycles a long op occupies Execute; legal range 2..16.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- ra_d  in  NSRC*AW  Decode source addresses; source i is bits [i*AW +: AW].
- use_d  in  NSRC  Decode source i is read.
- ra_e  in  NSRC*AW  Execute source addresses.
- use_e  in  NSRC  Execute source i is read.
- wa_e, wa_m, wa_w  in  AW each  destination address in E, M and W.
- regwrite_e, regwrite_m, regwrite_w  in  1 each  destination valid.
- memtoreg_e  in  1  load in Execute.
- long_e  in  1  long-latency op in Execute.
- branch_taken_e  in  1  taken branch resolved in Execute.
- forward_e  out  2*NSRC  per-source select: 00 regfile, 01 W result, 10 M ALU result.
- stall_f, stall_d, stall_e  out  1 each  hold stage register.
- flush_d, flush_e  out  1 each  clear stage register (bubble).
- busy  out  1  multicycle controller not IDLE.

Behaviour:
- All outputs are combinational from inputs plus registered state. There is no added output latency.
- Reset: state=IDLE, cnt=0, busy=0. With all inputs 0, every output is 0. Reset asserted mid-op forces IDLE asynchronously; stalls drop in the same cycle.
- Forwarding, per source i:
  - 10 if use_e[i] && regwrite_m && wa_m==ra_e[i] && ra_e[i]!=all-ones.
  - else 01 if the same test holds with the W-stage signals.
  - else 00.
  - M has priority over W. Forwarding is evaluated in every state.
- Load-use: ldstall = memtoreg_e && regwrite_e && OR over i of (use_d[i] && ra_d[i]==wa_e). ldstall drives stall_f, stall_d and flush_e.
- long_eff = long_e && !memtoreg_e; a load takes precedence if both are asserted.
- FSM, internal counter cnt of width clog2(LONG_LAT):
  - IDLE: if long_eff, assert lstall this cycle. Next state is RELEASE if LONG_LAT==2, else BUSY with cnt=LONG_LAT-3.
  - BUSY: lstall asserted. If cnt==0, next RELEASE; else cnt-=1.
  - RELEASE: lstall deasserted and long_e ignored; the op leaves E at the end of this cycle. Next IDLE.
  - Total lstall cycles = LONG_LAT-1, so the op occupies E for LONG_LAT cycles.
  - busy=1 in BUSY and RELEASE, and in IDLE whenever lstall is asserted.
- Output equations:
  - stall_f = ldstall | lstall.
  - stall_d = ldstall | lstall.
  - stall_e = lstall.
  - flush_e = (ldstall | branch_taken_e) && !lstall. Execute must hold, never bubble, during a long op.
  - flush_d = branch_taken_e && !lstall.
- Branch during RELEASE: flush_d=1 and flush_e=1, no stall.
- Back-to-back long ops: the second op is seen in IDLE the cycle after RELEASE and restarts the sequence.

Test Plan:
- NSRC=3, ra_e={r2,r1,r1}, use_e=111, wa_m=r1, regwrite_m=1, wa_w=r2, regwrite_w=1 -> forward_e=6'b01_10_10; with ra_e[0]=4'hF -> source 0 selects 00.
- memtoreg_e=1, regwrite_e=1, wa_e=r3, ra_d[1]=r3, use_d=010 -> stall_f=stall_d=flush_e=1, stall_e=0. Repeat with use_d=000 -> all 0.
- LONG_LAT=4, long_e held high from t0 until the op leaves -> lstall at t0..t2 (stall_e=1, flush_e=0), RELEASE at t3 with stalls 0, IDLE at t4, busy=1 for t0..t3.
- LONG_LAT=2 -> exactly one stall cycle, then RELEASE.
- BUSY with branch_taken_e=1 -> flush_d=flush_e=0. Same stimulus in IDLE -> flush_d=flush_e=1.
- Assert rst during BUSY -> busy and stalls go to 0 before the next clk edge. After release, long_e=1 restarts a full LONG_LAT sequence.
